// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one pass through the shared 32-bit adder per cycle, 64-bit product.
// Optional two's-complement support is built when SEQ_MULT_SIGNED_EN is defined.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SEQ_MULT_SIGNED_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FIX  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] m, hi, lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] add_b, sum;
  logic             cout;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH-1:0] m_load, lo_load;
  logic [PW-1:0]    result;

  // Shared adder in add mode; its carry-out is shifted into hi so no product bit is lost.
  always_comb begin
    add_b         = lo[0] ? m : '0;
    {cout, sum}   = {1'b0, hi} + {1'b0, add_b};
    hi_step       = {cout, sum[WIDTH-1:1]};
    lo_step       = {sum[0], lo[WIDTH-1:1]};
  end

`ifdef SEQ_MULT_SIGNED_EN
  logic          neg, neg_load;
  logic [PW-1:0] fix_val;

  // Operand magnitudes and the final negate use dedicated incrementers, not the shared adder.
  always_comb begin
    m_load   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    lo_load  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_load = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0) && (b != '0);
    fix_val  = ~{hi, lo} + PW'(1);
    result   = (state == S_FIX) ? fix_val : {hi_step, lo_step};
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign m_load  = a;
  assign lo_load = b;
  assign result  = {hi_step, lo_step};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_RUN;
      S_RUN: begin
        if (cnt == LAST) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_n = neg ? S_FIX : S_DONE;
`else
          state_n = S_DONE;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      S_FIX:  state_n = S_DONE;
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, steered by the current/next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      cnt     <= '0;
      m       <= '0;
      hi      <= '0;
      lo      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      busy <= (state_n != S_IDLE);
      done <= (state_n == S_DONE);
      if (state_n == S_DONE) product <= result;
      case (state)
        S_IDLE: begin
          if (start) begin
            m   <= m_load;
            hi  <= '0;
            lo  <= lo_load;
            cnt <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg <= neg_load;
`endif
          end
        end
        S_RUN: begin
          hi  <= hi_step;
          lo  <= lo_step;
          cnt <= cnt + CW'(1);
        end
`ifdef SEQ_MULT_SIGNED_EN
        S_FIX: {hi, lo} <= fix_val;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against an arithmetic reference model.
module tb_seq_multiplier;

`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Mathematical product: plain 64-bit arithmetic on the operand values.
  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [63:0] sx, sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s && SIGNED_BUILD) return 64'(sx * sy);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // A negative signed result costs one extra edge for the final negate.
  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] p;
    p = ref_prod(x, y, s);
    return (s && SIGNED_BUILD && p[63]) ? 33 : 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and observe it through to the IDLE cycle after DONE.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        output logic [63:0] p, output int lat, output int busy_bad,
                        output int after_bad);
    a = ia; b = ib; is_signed = is; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom);
    lat = 0;
    busy_bad = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_bad++;
    p = product;
    tick();
    after_bad = (busy !== 1'b0 || done !== 1'b0 || product !== p) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", product); end
  endtask

  task automatic test_directed(input logic [31:0] x, input logic [31:0] y, input logic s, input string name);
    logic [63:0] p, exp_p;
    int lat, bb, ab, exp_l;
    exp_p = ref_prod(x, y, s);
    exp_l = ref_lat(x, y, s);
    run_op(x, y, s, p, lat, bb, ab);
    checks++; if (p !== exp_p) begin errors++; $display("FAIL %s_product: got %h expected %h", name, p, exp_p); end
    checks++; if (lat !== exp_l) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_l); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL %s_busy_low_while_active: got %0d cycles expected 0", name, bb); end
    checks++; if (ab !== 0) begin errors++; $display("FAIL %s_after_done: got busy=%b done=%b expected 0/0 with product held", name, busy, done); end
  endtask

  task automatic test_ignore_start();
    logic [63:0] p;
    int k, lat, bb, ab;
    a = 32'd7; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    repeat (4) begin tick(); k++; end
    a = 32'd9; b = 32'd9; start = 1'b1;
    tick(); k++;
    start = 1'b0;
    while (done !== 1'b1 && k < 40) begin tick(); k++; end
    checks++; if (k !== 32) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 32", k); end
    checks++; if (product !== 64'd42) begin errors++; $display("FAIL ignore_start_product: got %h expected %h", product, 64'd42); end
    tick();
    run_op(32'd9, 32'd9, 1'b0, p, lat, bb, ab);
    checks++; if (p !== 64'd81) begin errors++; $display("FAIL restart_product: got %h expected %h", p, 64'd81); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL restart_latency: got %0d expected 32", lat); end
  endtask

  task automatic test_reset_mid_run();
    logic [63:0] p;
    int lat, bb, ab;
    a = 32'd7; b = 32'd6; is_signed = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL midreset_product: got %h expected 0", product); end
    run_op(32'd2, 32'd3, 1'b0, p, lat, bb, ab);
    checks++; if (p !== 64'd6) begin errors++; $display("FAIL postreset_product: got %h expected %h", p, 64'd6); end
    checks++; if (lat !== 32) begin errors++; $display("FAIL postreset_latency: got %0d expected 32", lat); end
  endtask

  // Back-to-back random operations, operands biased toward the sign/zero corners.
  task automatic test_back_to_back_random();
    logic [31:0] x, y;
    logic        s;
    logic [63:0] p, exp_p;
    int lat, bb, ab, exp_l;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 7))
        0: x = 32'h0;
        1: x = 32'h8000_0000;
        2: x = 32'hFFFF_FFFF;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'h0;
        1: y = 32'h8000_0000;
        2: y = 32'h0000_0001;
        default: y = $urandom;
      endcase
      s = 1'($urandom);
      exp_p = ref_prod(x, y, s);
      exp_l = ref_lat(x, y, s);
      run_op(x, y, s, p, lat, bb, ab);
      checks++; if (p !== exp_p) begin errors++; $display("FAIL rand%0d_product: a=%h b=%h s=%b got %h expected %h", i, x, y, s, p, exp_p); end
      checks++; if (lat !== exp_l) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, exp_l); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL rand%0d_busy: got %0d low cycles expected 0", i, bb); end
      checks++; if (ab !== 0) begin errors++; $display("FAIL rand%0d_after_done: got busy=%b done=%b expected 0/0", i, busy, done); end
    end
  endtask

  initial begin
    test_reset();
    test_directed(32'd7, 32'd6, 1'b0, "u7x6");
    test_directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "uffxff");
    test_directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ffxff_sflag");
`ifdef SEQ_MULT_SIGNED_EN
    test_directed(32'hFFFF_FFFD, 32'd5, 1'b1, "s_m3x5");
    test_directed(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin");
    test_directed(32'h8000_0000, 32'd1, 1'b1, "s_minx1");
    test_directed(32'hFFFF_FFFF, 32'd0, 1'b1, "s_m1x0");
`endif
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
